// File: rtl/vga_sync_gen.sv
// 640x480@60Hz VGA timing generator: pixel-rate divider, h/v counters, registered syncs.
// Latency: counters, syncs and frame_start all update on the same clk edge; video_on follows combinationally.
module vga_sync_gen #(
  parameter int DIV      = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SW + V_BP;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS   = 10'(H_DISP);
  localparam logic [9:0]    V_VIS   = 10'(V_DISP);
  localparam logic [9:0]    HS_BEG  = 10'(H_DISP + H_FP);
  localparam logic [9:0]    HS_END  = 10'(H_DISP + H_FP + H_SW - 1);
  localparam logic [9:0]    VS_BEG  = 10'(V_DISP + V_FP);
  localparam logic [9:0]    VS_END  = 10'(V_DISP + V_FP + V_SW - 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          hs_nxt;
  logic          vs_nxt;

  assign p_tick = (div_cnt == DIV_MAX);
  assign h_wrap = (pix_x == H_MAX);
  assign v_wrap = (pix_y == V_MAX);

  always_comb begin
    x_nxt = pix_x;
    y_nxt = pix_y;
    if (p_tick) begin
      x_nxt = h_wrap ? 10'd0 : pix_x + 10'd1;
      if (h_wrap) begin
        y_nxt = v_wrap ? 10'd0 : pix_y + 10'd1;
      end
    end
  end

  // Syncs decode the next-state counters so they land on the same edge as pix_x/pix_y.
  assign hs_nxt = (x_nxt >= HS_BEG) && (x_nxt <= HS_END);
  assign vs_nxt = (y_nxt >= VS_BEG) && (y_nxt <= VS_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= p_tick ? '0 : div_cnt + DW'(1);
      pix_x       <= x_nxt;
      pix_y       <= y_nxt;
      hsync       <= hs_nxt ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_nxt ? SYNC_POL : ~SYNC_POL;
      frame_start <= p_tick && h_wrap && v_wrap;
    end
  end

  assign video_on = (pix_x < H_VIS) && (pix_y < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size instance for line timing, reduced-size active-high-sync instance for frame timing.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst, rst_s;
  logic       p_tick, video_on, hsync, vsync, frame_start;
  logic [9:0] pix_x, pix_y;
  logic       p_tick_s, video_on_s, hsync_s, vsync_s, frame_start_s;
  logic [9:0] pix_x_s, pix_y_s;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .reset(rst), .p_tick(p_tick), .pix_x(pix_x), .pix_y(pix_y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  // Small frame: H_TOTAL=15 (sync 10..12), V_TOTAL=12 (sync 8..9), 2 clk/pixel, active-high syncs.
  vga_sync_gen #(
    .DIV(2), .H_DISP(8), .H_FP(2), .H_SW(3), .H_BP(2),
    .V_DISP(6), .V_FP(2), .V_SW(2), .V_BP(2), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .reset(rst_s), .p_tick(p_tick_s), .pix_x(pix_x_s), .pix_y(pix_y_s),
    .video_on(video_on_s), .hsync(hsync_s), .vsync(vsync_s), .frame_start(frame_start_s)
  );

  task automatic reset_main();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reset_small();
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
  endtask

  task automatic test_reset();
    int first_t;
    rst = 1'b1; rst_s = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (pix_x !== 10'd0) begin errors++; $display("FAIL rst_pix_x got %0d want 0", pix_x); end
    vectors++; if (pix_y !== 10'd0) begin errors++; $display("FAIL rst_pix_y got %0d want 0", pix_y); end
    vectors++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL rst_sync got h=%b v=%b want 1/1", hsync, vsync); end
    vectors++; if (p_tick !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL rst_pulses got tick=%b fs=%b want 0/0", p_tick, frame_start); end
    vectors++; if (video_on !== 1'b1) begin errors++; $display("FAIL rst_video_on got %b want 1", video_on); end
    vectors++; if (hsync_s !== 1'b0 || vsync_s !== 1'b0) begin errors++; $display("FAIL rst_sync_pol got h=%b v=%b want 0/0", hsync_s, vsync_s); end
    rst = 1'b0;
    first_t = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (p_tick === 1'b1 && first_t == 0) first_t = c;
    end
    vectors++; if (first_t !== 3) begin errors++; $display("FAIL first_tick got edge %0d want edge 3", first_t); end
    vectors++; if (pix_x !== 10'd1) begin errors++; $display("FAIL first_advance got %0d want 1", pix_x); end
  endtask

  task automatic test_line();
    int prev_x, exp_x, last_t, gap_bad, step_bad, hwin_bad, vs_bad, fs_cnt, nticks, first_t;
    int h_fall_cyc, h_fall_x, h_rise_cyc, h_rise_x, w1_cyc, w1_y, w2_cyc, w2_y;
    logic prev_t, prev_h;
    reset_main();
    prev_x = int'(pix_x); prev_t = p_tick; prev_h = hsync;
    last_t = 0; gap_bad = 0; step_bad = 0; hwin_bad = 0; vs_bad = 0; fs_cnt = 0; nticks = 0; first_t = 0;
    h_fall_cyc = -1; h_fall_x = -1; h_rise_cyc = -1; h_rise_x = -1;
    w1_cyc = -1; w1_y = -1; w2_cyc = -1; w2_y = -1;
    for (int cyc = 1; cyc <= 6500; cyc++) begin
      @(negedge clk);
      if (p_tick === 1'b1) begin
        if (last_t > 0 && cyc - last_t != 4) gap_bad++;
        if (first_t == 0) first_t = cyc;
        last_t = cyc;
        nticks++;
      end
      exp_x = prev_t ? ((prev_x == 799) ? 0 : prev_x + 1) : prev_x;
      if (int'(pix_x) !== exp_x) step_bad++;
      if (hsync !== !(pix_x >= 10'd656 && pix_x <= 10'd751)) hwin_bad++;
      if (vsync !== 1'b1) vs_bad++;
      if (frame_start !== 1'b0) fs_cnt++;
      if (prev_h === 1'b1 && hsync === 1'b0 && h_fall_cyc < 0) begin h_fall_cyc = cyc; h_fall_x = int'(pix_x); end
      if (prev_h === 1'b0 && hsync === 1'b1 && h_rise_cyc < 0) begin h_rise_cyc = cyc; h_rise_x = int'(pix_x); end
      if (prev_x == 799 && pix_x == 10'd0) begin
        if (w1_cyc < 0) begin w1_cyc = cyc; w1_y = int'(pix_y); end
        else if (w2_cyc < 0) begin w2_cyc = cyc; w2_y = int'(pix_y); end
      end
      prev_x = int'(pix_x); prev_t = p_tick; prev_h = hsync;
    end
    vectors++; if (first_t !== 3) begin errors++; $display("FAIL line_first_tick got %0d want 3", first_t); end
    vectors++; if (gap_bad !== 0) begin errors++; $display("FAIL tick_period got %0d bad gaps want 0", gap_bad); end
    vectors++; if (nticks !== 1625) begin errors++; $display("FAIL tick_count got %0d want 1625", nticks); end
    vectors++; if (step_bad !== 0) begin errors++; $display("FAIL pix_x_step got %0d bad steps want 0", step_bad); end
    vectors++; if (hwin_bad !== 0) begin errors++; $display("FAIL hsync_window got %0d bad cycles want 0", hwin_bad); end
    vectors++; if (vs_bad !== 0) begin errors++; $display("FAIL vsync_idle got %0d bad cycles want 0", vs_bad); end
    vectors++; if (fs_cnt !== 0) begin errors++; $display("FAIL line_no_fs got %0d pulses want 0", fs_cnt); end
    vectors++; if (h_fall_x !== 656 || h_fall_cyc !== 2624) begin errors++; $display("FAIL hsync_fall got x=%0d cyc=%0d want 656/2624", h_fall_x, h_fall_cyc); end
    vectors++; if (h_rise_x !== 752 || h_rise_cyc - h_fall_cyc !== 384) begin errors++; $display("FAIL hsync_rise got x=%0d width=%0d want 752/384", h_rise_x, h_rise_cyc - h_fall_cyc); end
    vectors++; if (w1_cyc !== 3200 || w1_y !== 1) begin errors++; $display("FAIL line_wrap1 got cyc=%0d y=%0d want 3200/1", w1_cyc, w1_y); end
    vectors++; if (w2_cyc - w1_cyc !== 3200 || w2_y !== 2) begin errors++; $display("FAIL line_period got %0d y=%0d want 3200/2", w2_cyc - w1_cyc, w2_y); end
  endtask

  task automatic test_video_main();
    logic s1, s2, done;
    s1 = 1'b0; s2 = 1'b0; done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (pix_x == 10'd639 && !s1) begin
        s1 = 1'b1;
        vectors++; if (video_on !== 1'b1) begin errors++; $display("FAIL vid_639 got %b want 1", video_on); end
      end else if (pix_x == 10'd640 && s1 && !s2) begin
        s2 = 1'b1;
        vectors++; if (video_on !== 1'b0) begin errors++; $display("FAIL vid_640 got %b want 0", video_on); end
      end else if (pix_x == 10'd0 && s2) begin
        done = 1'b1;
        vectors++; if (video_on !== 1'b1 || pix_y !== 10'd3) begin errors++; $display("FAIL vid_line_start got on=%b y=%0d want 1/3", video_on, pix_y); end
      end
    end
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL vid_main_timeout got done=%b want 1", done); end
  endtask

  task automatic test_frame();
    int fs_cnt, fs1, fs2, fs_pos_bad, fs_wide, vwin_bad, hwin_bad, vs_clks, vs_first, range_bad;
    logic prev_fs, v75, v80, v06, v00;
    reset_small();
    fs_cnt = 0; fs1 = -1; fs2 = -1; fs_pos_bad = 0; fs_wide = 0; vwin_bad = 0; hwin_bad = 0;
    vs_clks = 0; vs_first = -1; range_bad = 0; prev_fs = 1'b0;
    v75 = 1'bx; v80 = 1'bx; v06 = 1'bx; v00 = 1'bx;
    for (int cyc = 1; cyc <= 800; cyc++) begin
      @(negedge clk);
      if (frame_start_s === 1'b1) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = cyc; else if (fs2 < 0) fs2 = cyc;
        if (pix_x_s != 10'd0 || pix_y_s != 10'd0) fs_pos_bad++;
        if (prev_fs === 1'b1) fs_wide++;
        v00 = video_on_s;
      end
      prev_fs = frame_start_s;
      if (vsync_s !== (pix_y_s >= 10'd8 && pix_y_s <= 10'd9)) vwin_bad++;
      if (hsync_s !== (pix_x_s >= 10'd10 && pix_x_s <= 10'd12)) hwin_bad++;
      if (vsync_s === 1'b1) begin vs_clks++; if (vs_first < 0) vs_first = cyc; end
      if (pix_x_s > 10'd14 || pix_y_s > 10'd11) range_bad++;
      if (pix_x_s == 10'd7 && pix_y_s == 10'd5) v75 = video_on_s;
      if (pix_x_s == 10'd8 && pix_y_s == 10'd0) v80 = video_on_s;
      if (pix_x_s == 10'd0 && pix_y_s == 10'd6) v06 = video_on_s;
    end
    vectors++; if (fs_cnt !== 2 || fs1 !== 360 || fs2 !== 720) begin errors++; $display("FAIL frame_start_times got n=%0d at %0d,%0d want 2 at 360,720", fs_cnt, fs1, fs2); end
    vectors++; if (fs_pos_bad !== 0 || fs_wide !== 0) begin errors++; $display("FAIL frame_start_shape got pos=%0d wide=%0d want 0/0", fs_pos_bad, fs_wide); end
    vectors++; if (vwin_bad !== 0) begin errors++; $display("FAIL vsync_window got %0d bad cycles want 0", vwin_bad); end
    vectors++; if (hwin_bad !== 0) begin errors++; $display("FAIL hsync_pol_window got %0d bad cycles want 0", hwin_bad); end
    vectors++; if (vs_first !== 240 || vs_clks !== 120) begin errors++; $display("FAIL vsync_timing got first=%0d clks=%0d want 240/120", vs_first, vs_clks); end
    vectors++; if (range_bad !== 0) begin errors++; $display("FAIL counter_range got %0d bad want 0", range_bad); end
    vectors++; if (v75 !== 1'b1 || v80 !== 1'b0 || v06 !== 1'b0 || v00 !== 1'b1) begin
      errors++; $display("FAIL vid_corners got %b%b%b%b want 1001", v75, v80, v06, v00);
    end
  endtask

  task automatic test_midreset();
    logic found;
    int first_fs, first_t;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (pix_x_s == 10'd11 && pix_y_s == 10'd9) found = 1'b1;
    end
    vectors++; if (found !== 1'b1 || hsync_s !== 1'b1 || vsync_s !== 1'b1) begin errors++; $display("FAIL pre_reset_syncs got found=%b h=%b v=%b want 1/1/1", found, hsync_s, vsync_s); end
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    vectors++; if (pix_x_s !== 10'd0 || pix_y_s !== 10'd0 || hsync_s !== 1'b0 || vsync_s !== 1'b0 || frame_start_s !== 1'b0) begin
      errors++; $display("FAIL midreset_state got x=%0d y=%0d h=%b v=%b fs=%b want 0/0/0/0/0", pix_x_s, pix_y_s, hsync_s, vsync_s, frame_start_s);
    end
    first_fs = -1; first_t = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (frame_start_s === 1'b1 && first_fs < 0) first_fs = cyc;
      if (p_tick_s === 1'b1 && first_t < 0) first_t = cyc;
    end
    vectors++; if (first_t !== 1 || first_fs !== 360) begin errors++; $display("FAIL midreset_resume got tick=%0d fs=%0d want 1/360", first_t, first_fs); end

    found = 1'b0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (pix_x == 10'd700) found = 1'b1;
    end
    vectors++; if (found !== 1'b1 || hsync !== 1'b0) begin errors++; $display("FAIL pre_reset_hsync got found=%b h=%b want 1/0", found, hsync); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (pix_x !== 10'd0 || pix_y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 || p_tick !== 1'b0) begin
      errors++; $display("FAIL midreset_main got x=%0d y=%0d h=%b v=%b t=%b want 0/0/1/1/0", pix_x, pix_y, hsync, vsync, p_tick);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_s = 1'b1;
    test_reset();
    test_line();
    test_video_main();
    test_frame();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
